dmem_responder: RTL and testbench

//  Data-memory responder for the RV32I MEM stage: the memory side of the

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_responder.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: load/store request and response bundle between the MEM stage
// (master) and the data-memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind the MEM-stage port, with
// byte/half lanes, load extension, error flags and programmable wait states.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AW    = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic [31:0]           word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_val;
    logic [31:0]           st_data;
    logic [3:0]            st_be;
    logic                  illegal;
    logic                  misaligned;
    logic                  err;
    logic                  mem_we;
    logic                  accept;

    // Upper address bits alias onto the RAM and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, bus.req_addr[31:AW]};

    assign idx      = addr_q[AW-1:2];
    assign lane     = addr_q[1:0];
    assign word     = mem[idx];
    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        load_val   = 32'h0;
        st_data    = 32'h0;
        st_be      = 4'b0000;
        case (funct3_q)
            3'b000: begin
                load_val = {{24{byte_sel[7]}}, byte_sel};
                st_data  = {4{wdata_q[7:0]}};
                st_be    = 4'b0001 << lane;
            end
            3'b001: begin
                misaligned = lane[0];
                load_val   = {{16{half_sel[15]}}, half_sel};
                st_data    = {2{wdata_q[15:0]}};
                st_be      = lane[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                misaligned = (lane != 2'b00);
                load_val   = word;
                st_data    = wdata_q;
                st_be      = 4'b1111;
            end
            3'b100: begin
                illegal  = write_q;
                load_val = {24'h0, byte_sel};
            end
            3'b101: begin
                illegal    = write_q;
                misaligned = lane[0];
                load_val   = {16'h0, half_sel};
            end
            default: illegal = 1'b1;
        endcase
        err = illegal | misaligned;
    end

    assign mem_we = (state_q == S_RESP) && write_q && !err;
    assign accept = bus.req_valid && (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr[AW-1:0];
                    wdata_d  = bus.req_wdata;
                    cnt_d    = 4'(WAIT_STATES);
                    state_d  = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            // The access commits on the edge leaving this state.
            S_RESP: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = err;
                rsp_rdata_d = (err || write_q) ? 32'h0 : load_val;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors, reset/latency/throughput sequences
// and a byte-array reference model for random traffic.
module tb_dmem_responder;
    typedef struct {
        bit        w;
        bit [2:0]  f3;
        bit [31:0] a;
        bit [31:0] wd;
        bit [31:0] rd;
        bit        er;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        wr;
    logic [2:0]  f3r;
    logic [31:0] addr;
    logic [31:0] wdat;
    int          sel;

    logic        ready_m;
    logic        rv_m;
    logic [31:0] rd_m;
    logic        err_m;

    int ncmp = 0;
    int nbad = 0;

    logic [7:0] bmem [4096];
    vec_t       tv [$];

    dmem_if b0 ();
    dmem_if b1 ();
    dmem_if b3 ();

    assign b0.req_valid  = vld && (sel == 0);
    assign b1.req_valid  = vld && (sel == 1);
    assign b3.req_valid  = vld && (sel == 2);
    assign b0.req_write  = wr;
    assign b1.req_write  = wr;
    assign b3.req_write  = wr;
    assign b0.req_funct3 = f3r;
    assign b1.req_funct3 = f3r;
    assign b3.req_funct3 = f3r;
    assign b0.req_addr   = addr;
    assign b1.req_addr   = addr;
    assign b3.req_addr   = addr;
    assign b0.req_wdata  = wdat;
    assign b1.req_wdata  = wdat;
    assign b3.req_wdata  = wdat;

    assign ready_m = (sel == 0) ? b0.req_ready :
                     (sel == 1) ? b1.req_ready : b3.req_ready;
    assign rv_m    = (sel == 0) ? b0.rsp_valid :
                     (sel == 1) ? b1.rsp_valid : b3.rsp_valid;
    assign rd_m    = (sel == 0) ? b0.rsp_rdata :
                     (sel == 1) ? b1.rsp_rdata : b3.rsp_rdata;
    assign err_m   = (sel == 0) ? b0.rsp_err :
                     (sel == 1) ? b1.rsp_err : b3.rsp_err;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .bus(b3.slave)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic int wsv(input int s);
        return (s == 0) ? 0 : (s == 1) ? 1 : 3;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic add(input bit w, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit [31:0] rd,
                       input bit er);
        vec_t v;
        v.w = w; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd; v.er = er;
        tv.push_back(v);
    endtask

    // Little-endian byte memory; sizes and extension from funct3 alone.
    task automatic model(input bit w, input bit [2:0] f3,
                         input bit [31:0] a, input bit [31:0] wd,
                         output bit [31:0] rd, output bit er);
        int     sz;
        bit     sx;
        bit     ok;
        int     base;
        longint v;
        ok = 1'b1; sx = 1'b0; sz = 1;
        case (f3)
            3'd0: begin sz = 1; sx = 1'b1; end
            3'd1: begin sz = 2; sx = 1'b1; end
            3'd2: sz = 4;
            3'd4: begin sz = 1; ok = !w; end
            3'd5: begin sz = 2; ok = !w; end
            default: ok = 1'b0;
        endcase
        base = int'(a % 4096);
        er = !ok || (base % sz != 0);
        rd = 32'h0;
        if (er) return;
        if (w) begin
            for (int k = 0; k < sz; k++) bmem[base+k] = 8'(wd >> (8*k));
        end else begin
            v = 0;
            for (int k = 0; k < sz; k++)
                v += longint'(bmem[base+k]) << (8*k);
            if (sx && v >= (longint'(1) << (8*sz-1)))
                v -= longint'(1) << (8*sz);
            rd = 32'(v);
        end
    endtask

    task automatic txn(input int s, input bit w, input bit [2:0] f3,
                       input bit [31:0] a, input bit [31:0] wd,
                       output logic [31:0] rd, output logic er);
        int lat;
        bit got;
        @(negedge clk);
        sel = s; wr = w; f3r = f3; addr = a; wdat = wd; vld = 1'b1;
        chk("ready before accept", 32'(ready_m), 32'd1);
        @(posedge clk);
        #1;
        vld = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (rv_m) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        if (!got) begin
            chk("response timeout", 32'd0, 32'd1);
            rd = 32'h0;
            er = 1'b0;
            return;
        end
        rd = rd_m;
        er = err_m;
        chk($sformatf("latency ws%0d", wsv(s)), 32'(lat), 32'(wsv(s) + 1));
        @(posedge clk);
        #1;
        chk("single-cycle pulse", 32'(rv_m), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    bit [31:0]   mrd;
    bit          mer;

    initial begin
        int nacc;
        int nrsp;
        int last;
        bit seen;
        bit        rw;
        bit [2:0]  rf;
        bit [31:0] ra;
        bit [31:0] rwd;

        rst = 1'b1; vld = 1'b0; wr = 1'b0; f3r = 3'd0;
        addr = 32'h0; wdat = 32'h0; sel = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset ready", 32'(ready_m), 32'd1);
            chk("reset rsp_valid", 32'(rv_m), 32'd0);
            chk("reset rdata", rd_m, 32'h0);
            chk("reset err", 32'(err_m), 32'd0);
        end

        add(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        add(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        add(1, 3'd0, 32'h13, 32'h80, 32'h0, 0);
        add(0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
        add(0, 3'd4, 32'h13, 32'h0, 32'h00000080, 0);
        add(0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 0);
        add(1, 3'd1, 32'h12, 32'h1234, 32'h0, 0);
        add(0, 3'd1, 32'h12, 32'h0, 32'h00001234, 0);
        add(0, 3'd1, 32'h11, 32'h0, 32'h0, 1);
        add(0, 3'd2, 32'h10, 32'h0, 32'h1234BEEF, 0);
        add(1, 3'd2, 32'h14, 32'h11223344, 32'h0, 0);
        add(1, 3'd2, 32'h16, 32'hFFFFFFFF, 32'h0, 1);
        add(0, 3'd2, 32'h14, 32'h0, 32'h11223344, 0);
        add(0, 3'd3, 32'h14, 32'h0, 32'h0, 1);
        add(1, 3'd4, 32'h14, 32'h55, 32'h0, 1);
        add(0, 3'd2, 32'h14, 32'h0, 32'h11223344, 0);
        add(0, 3'd5, 32'h16, 32'h0, 32'h00001122, 0);
        add(0, 3'd0, 32'h17, 32'h0, 32'h00000011, 0);
        add(1, 3'd0, 32'h17, 32'hF0, 32'h0, 0);
        add(0, 3'd1, 32'h16, 32'h0, 32'hFFFFF022, 0);
        add(0, 3'd5, 32'h16, 32'h0, 32'h0000F022, 0);
        add(0, 3'd4, 32'h14, 32'h0, 32'h00000044, 0);
        add(0, 3'd1, 32'h15, 32'h0, 32'h0, 1);
        add(0, 3'd6, 32'h14, 32'h0, 32'h0, 1);
        add(1, 3'd7, 32'h14, 32'h0, 32'h0, 1);
        add(1, 3'd1, 32'h13, 32'hBEEF, 32'h0, 1);
        add(1, 3'd5, 32'h14, 32'hBEEF, 32'h0, 1);
        add(0, 3'd2, 32'h14, 32'h0, 32'hF0223344, 0);
        add(0, 3'd2, 32'h1010, 32'h0, 32'h1234BEEF, 0);
        add(1, 3'd2, 32'hFFFFF010, 32'h0BADF00D, 32'h0, 0);
        add(0, 3'd2, 32'h10, 32'h0, 32'h0BADF00D, 0);
        add(0, 3'd2, 32'h80000014, 32'h0, 32'hF0223344, 0);

        foreach (tv[i]) begin
            txn(1, tv[i].w, tv[i].f3, tv[i].a, tv[i].wd, rd, er);
            chk($sformatf("vec%0d rdata", i), rd, tv[i].rd);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(tv[i].er));
        end

        for (int s = 0; s < 3; s++) begin
            txn(s, 1, 3'd2, 32'h20, 32'h12345678, rd, er);
            chk("rst prior err", 32'(er), 32'd0);
            @(negedge clk);
            sel = s; wr = 1'b1; f3r = 3'd2;
            addr = 32'h20; wdat = 32'hAAAA5555; vld = 1'b1;
            @(posedge clk);
            #2;
            vld = 1'b0;
            rst = 1'b1;
            #2;
            rst = 1'b0;
            #1;
            chk("rst ready after release", 32'(ready_m), 32'd1);
            seen = 1'b0;
            repeat (8) begin
                @(posedge clk);
                #1;
                if (rv_m) seen = 1'b1;
            end
            chk("rst dropped no rsp", 32'(seen), 32'd0);
            txn(s, 0, 3'd2, 32'h20, 32'h0, rd, er);
            chk("rst no commit", rd, 32'h12345678);
            chk("rst reload err", 32'(er), 32'd0);
        end

        @(negedge clk);
        sel = 1; wr = 1'b0; f3r = 3'd2; addr = 32'h10; vld = 1'b1;
        nacc = 0; nrsp = 0; last = 0;
        for (int i = 0; i < 12; i++) begin
            if (ready_m) begin
                if (nacc > 0) chk("accept spacing", 32'(i - last), 32'd3);
                last = i;
                nacc++;
            end
            if (rv_m) begin
                nrsp++;
                chk("stream rdata", rd_m, 32'h0BADF00D);
            end
            @(negedge clk);
        end
        vld = 1'b0;
        chk("stream accepts", 32'(nacc), 32'd4);
        chk("stream responses", 32'(nrsp), 32'd3);
        repeat (4) @(negedge clk);

        for (int k = 0; k < 64; k++) begin
            rwd = $urandom;
            model(1'b1, 3'd2, 32'(k*4), rwd, mrd, mer);
            txn(1, 1'b1, 3'd2, 32'(k*4), rwd, rd, er);
            chk("init err", 32'(er), 32'(mer));
        end
        for (int n = 0; n < 300; n++) begin
            rw  = 1'($urandom_range(0, 1));
            rf  = 3'($urandom_range(0, 7));
            ra  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
            rwd = $urandom;
            model(rw, rf, ra, rwd, mrd, mer);
            txn(1, rw, rf, ra, rwd, rd, er);
            chk($sformatf("rand%0d rdata", n), rd, mrd);
            chk($sformatf("rand%0d err", n), 32'(er), 32'(mer));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
